sap_prog_loader: RTL and testbench

//  Program loader for the SAP-1 16x8 program RAM: the writer side of the RAM that the CPU only reads.

---
 rtl/sap_prog_loader.sv | 133 +++++++++++++
 tb/tb_sap_prog_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sap_prog_loader.sv
// Purpose: writes a streamed program into the SAP-1 16x8 RAM from address 0 and pads the remainder with FILL_BYTE.
// Latency: one cycle from stream accept (or fill step) to the registered RAM write; done rises the cycle after the last write.
// Backpressure: in_ready is high only in LOAD; bytes offered in any other state are held by the source, never dropped.
module sap_prog_loader #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter logic [DATA_W-1:0] FILL_BYTE = 8'hF0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cpu_clr_q, cpu_clr_d;

    // Next-state, write-pointer and registered-output computation.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                end
            end
            S_LOAD: begin
                // in_ready_q is high throughout LOAD, so this is the handshake.
                if (in_valid && in_ready_q) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = wptr_q;
                    ram_wdata_d = in_data;
                    wptr_d      = wptr_q + ONE;
                    // The last location ends the load even if in_last is low.
                    if (wptr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        wptr_d  = '0;
                    end else if (in_last) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = wptr_q;
                ram_wdata_d = FILL_BYTE;
                wptr_d      = wptr_q + ONE;
                if (wptr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    wptr_d  = '0;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) || (state_d == S_FILL);
        // Release the CPU only after the final write has been presented to the RAM.
        done_d     = (state_d == S_DONE) && (state_q == S_DONE);
        cpu_clr_d  = !done_d;
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_clr_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_clr_q   <= cpu_clr_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cpu_clr   = cpu_clr_q;

endmodule

// File: tb/tb_sap_prog_loader.sv
// Purpose: directed scoreboard bench for sap_prog_loader; expected RAM writes are queued, a monitor pops them.
// Latency: expects each write one cycle after its accept and done one cycle after the final write.
// Backpressure: sends wait (bounded) for in_ready before counting a byte as accepted.
module tb_sap_prog_loader;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_clr;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [11:0] exp_q[$];
    logic [3:0]  exp_addr;

    sap_prog_loader dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_clr   (cpu_clr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h with nothing expected", ram_addr, ram_wdata);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    errors++;
                    $display("FAIL ram_write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             ram_addr, ram_wdata, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr = 4'd0;
    endtask

    // Offer one byte and hold it until accepted; queues the write it must produce.
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", d);
        end else begin
            exp_q.push_back({exp_addr, d});
            exp_addr = exp_addr + 4'd1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_fill(input int from);
        for (int a = from; a < 16; a++) exp_q.push_back({4'(a), 8'hF0});
    endtask

    task automatic check_done(input string name);
        @(negedge clk);
        chk({name, "_done"},    done,    1);
        chk({name, "_cpu_clr"}, cpu_clr, 0);
        chk({name, "_busy"},    busy,    0);
        chk({name, "_ram_we"},  ram_we,  0);
        chk({name, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        int t0;
        clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        exp_addr = 4'd0;
        step(); step();
        @(negedge clk);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cpu_clr", cpu_clr, 1);
        clr = 1'b0;
        step();

        // Stream offered in IDLE is ignored.
        in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("idle_cpu_clr", cpu_clr, 1);

        // Full 16-byte back-to-back load, with a start pulse mid-load that must be ignored.
        pulse_start();
        @(negedge clk);
        chk("load_busy", busy, 1);
        chk("load_in_ready", in_ready, 1);
        step();
        for (int i = 0; i < 16; i++) begin
            if (i == 7) start = 1'b1;
            send(8'h10 + 8'(i), 1'b0);
            start = 1'b0;
        end
        @(negedge clk);
        chk("last_write_we", ram_we, 1);
        chk("last_write_cpu_clr", cpu_clr, 1);
        step();
        check_done("t1");

        // Reload from DONE.
        pulse_start();
        @(negedge clk);
        chk("reload_cpu_clr", cpu_clr, 1);
        chk("reload_done", done, 0);
        chk("reload_busy", busy, 1);
        step();
        for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i), 1'b0);
        step();
        check_done("t5");

        // Short program with fill.
        pulse_start();
        step();
        send(8'h09, 1'b0);
        send(8'h1A, 1'b0);
        send(8'hE0, 1'b1);
        expect_fill(3);
        for (int i = 0; i < 13; i++) begin
            step();
            @(negedge clk);
            chk("fill_we", ram_we, 1);
            chk("fill_in_ready", in_ready, 0);
        end
        step();
        check_done("t2");

        // Gappy stream: one byte on, two cycles off.
        pulse_start();
        step();
        send(8'h30, 1'b0);
        t0 = cyc;
        for (int i = 1; i < 16; i++) begin
            step(); step();
            send(8'h30 + 8'(i), 1'b0);
        end
        chk("gap_stream_cycles", cyc - t0 + 1, 46);
        step();
        check_done("t3");

        // Clear mid-load, then a fresh load restarts from address 0.
        pulse_start();
        step();
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_ram_we", ram_we, 0);
        chk("clr_busy", busy, 0);
        chk("clr_cpu_clr", cpu_clr, 1);
        chk("clr_done", done, 0);
        chk("clr_in_ready", in_ready, 0);
        step();
        pulse_start();
        step();
        send(8'h55, 1'b1);
        expect_fill(1);
        for (int i = 0; i < 16; i++) step();
        check_done("t4");

        step(); step();
        chk("final_pending", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
